// File: rtl/wb_fabric_loader.sv
// wb_fabric_loader: Wishbone initiator that streams configuration bits into the fabric-control responder.
// Build option: define WB_FABRIC_LOADER_READBACK_EN to read back and verify every PROG write.
module wb_fabric_loader #(
    parameter int          NUM_BL    = 32,
    parameter int          NUM_WL    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic        bit_valid_i,
    input  logic        bit_data_i,
    output logic        bit_ready_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [10:0] bit_count_o
);
    typedef enum logic [3:0] {
        IDLE, CTRL_RST, CTRL_EN, GET_BIT, WR_BIT, READ_BACK, CTRL_OFF, DONE, ERROR
    } state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d, we_q, we_d, done_q, done_d, err_q, err_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic [4:0]  bl_q, bl_d, wl_q, wl_d;
    logic [10:0] cnt_q, cnt_d, wd_q, wd_d;
    logic [15:0] wdog_q, wdog_d;
    logic        bus_st, ack, last, req_we, bl_wrap;
    logic [31:0] req_adr, req_dat;
    logic        dat_unused;

    assign dat_unused  = ^wbm_dat_i;
    assign ack         = cyc_q & wbm_ack_i;
    assign bus_st      = state_q == CTRL_RST || state_q == CTRL_EN || state_q == WR_BIT ||
                         state_q == READ_BACK || state_q == CTRL_OFF;
    assign last        = wd_q[4:0] == 5'(NUM_BL - 1) && wd_q[9:5] == 5'(NUM_WL - 1);
    assign bl_wrap     = bl_q == 5'(NUM_BL - 1);
    assign req_we      = state_q != READ_BACK;
    assign req_adr     = (state_q == WR_BIT || state_q == READ_BACK) ? BASE_ADDR + 32'h4 : BASE_ADDR;
    assign req_dat     = state_q == CTRL_RST ? 32'h2 :
                         state_q == CTRL_EN  ? 32'h4 :
                         state_q == WR_BIT   ? {21'b0, wd_q} : 32'h0;
    assign bit_ready_o = state_q == GET_BIT;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = 4'hF;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign bit_count_o = cnt_q;

    // Sequencer: opens one bus cycle per bus state (after an idle cycle), watches for ack or timeout.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        bl_d    = bl_q;
        wl_d    = wl_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        wdog_d  = wdog_q;
        done_d  = done_q;
        err_d   = err_q;
        if (bus_st) begin
            if (!cyc_q) begin
                cyc_d  = 1'b1;
                we_d   = req_we;
                adr_d  = req_adr;
                dat_d  = req_dat;
                wdog_d = '0;
            end else if (wbm_ack_i || wdog_q == 16'(TIMEOUT - 1)) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                adr_d = '0;
                dat_d = '0;
                if (!wbm_ack_i) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end
        case (state_q)
            IDLE, DONE, ERROR: if (start_i) begin
                state_d = CTRL_RST;
                done_d  = 1'b0;
                err_d   = 1'b0;
                cnt_d   = '0;
                bl_d    = '0;
                wl_d    = '0;
            end
            CTRL_RST: if (ack) state_d = CTRL_EN;
            CTRL_EN:  if (ack) state_d = GET_BIT;
            GET_BIT:  if (bit_valid_i) begin
                wd_d    = {bit_data_i, wl_q, bl_q};
                state_d = WR_BIT;
            end
            WR_BIT: if (ack) begin
                cnt_d = cnt_q + 11'd1;
                bl_d  = bl_wrap ? 5'd0 : bl_q + 5'd1;
                wl_d  = bl_wrap ? wl_q + 5'd1 : wl_q;
`ifdef WB_FABRIC_LOADER_READBACK_EN
                state_d = READ_BACK;
`else
                state_d = last ? CTRL_OFF : GET_BIT;
`endif
            end
`ifdef WB_FABRIC_LOADER_READBACK_EN
            READ_BACK: if (ack) begin
                err_d   = wbm_dat_i[10:0] != wd_q;
                state_d = wbm_dat_i[10:0] != wd_q ? ERROR : last ? CTRL_OFF : GET_BIT;
            end
`endif
            CTRL_OFF: if (ack) begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: ;
        endcase
    end

    // State and bus registers; reset releases the bus immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            wdog_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            wdog_q  <= wdog_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule
